custom_axi_lane_engine: RTL
===========================

CUSTOM_AXI_LANE_ENGINE -- requirements
Module: custom_axi_lane_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, total data width; must be a multiple of LANES.
REQ-002 SHALL have parameter LANES, default 2, number of independent lanes; LANE_W = DATA_WIDTH/LANES.
REQ-003 SHALL have parameter ITER_W, default 8, width of iteration count.
REQ-004 SHALL have ports, one clock and one reset; reset is asynchronous and active-high:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
start_i  in  1  request; sampled in IDLE only.
data_i  in  DATA_WIDTH  initial lane values, lane k = bits [k*LANE_W +: LANE_W].
operand_i  in  LANE_W  addend for ADD/SAT_ADD modes.
mode_i  in  2  mode_e.
iter_i  in  ITER_W  iteration count.
abort_i  in  1  abort in-flight operation.
result_o  out  DATA_WIDTH  packed lane results.
result_valid_o  out  1  result available.
result_ready_i  in  1  consumer accepts result.
wen_o  out  1  one-cycle write-enable pulse for register writeback.
status_o  out  status_e  current state.
busy_o  out  1  high when state != IDLE.
err_code_o  out  err_e  last error cause.
done_cnt_o  out  16  completed-transaction count.

Function
REQ-005 SHALL implement states IDLE, BUSY, DONE, ERROR (status_e); status_o SHALL equal the state register.
REQ-006 IDLE: start_i with iter_i != 0 and mode_i != RSVD SHALL latch data_i, operand_i, mode_i, iter_i and go to BUSY next cycle.
REQ-007 IDLE: start_i with iter_i == 0 SHALL go to ERROR, err_code_o = ERR_ZERO_ITER; with mode_i == RSVD SHALL go to ERROR, err_code_o = ERR_BAD_MODE (bad mode takes priority).
REQ-008 BUSY: every cycle each lane SHALL update in parallel per mode; remaining-iteration counter decrements; after exactly iter cycles in BUSY SHALL go to DONE.
REQ-009 Modes: INC = lane+1 mod 2^LANE_W; ADD = lane+operand mod 2^LANE_W; SAT_ADD = lane+operand clamped to all-ones; no carry between lanes.
REQ-010 Latency: start accepted at edge N SHALL give result_valid_o high after edge N+iter+1.
REQ-011 DONE: result_valid_o high, result_o stable until result_ready_i sampled high; then IDLE next cycle and done_cnt_o increments (wraps 0xFFFF->0).
REQ-012 wen_o SHALL pulse high for exactly the first DONE cycle, regardless of result_ready_i.
REQ-013 start_i in BUSY, DONE or ERROR SHALL be ignored (no latch, no error).
REQ-014 abort_i in BUSY SHALL go to ERROR next cycle, err_code_o = ERR_ABORT, no wen_o; abort_i in other states ignored; abort_i wins over final-iteration completion.
REQ-015 ERROR SHALL last one cycle then IDLE; err_code_o held until next accepted start, which clears it to ERR_NONE.
REQ-016 Illegal state encoding SHALL go to ERROR, err_code_o = ERR_STATE.
REQ-017 result_valid_o and result_ready_i high in same cycle SHALL complete transfer; start_i that cycle SHALL be ignored.

Reset
REQ-018 rst_i high SHALL immediately force: state IDLE, result_o 0, result_valid_o 0, wen_o 0, busy_o 0, err_code_o ERR_NONE, done_cnt_o 0, internal lanes/counter 0.
REQ-019 Reset mid-BUSY or mid-DONE SHALL discard the transaction with no wen_o pulse.

Structure
REQ-020 status_e, mode_e (INC, ADD, SAT_ADD, RSVD) and err_e (ERR_NONE, ERR_ZERO_ITER, ERR_BAD_MODE, ERR_ABORT, ERR_STATE) SHALL live in custom_axi_ip_pkg.
REQ-021 Per-lane arithmetic SHALL be a combinational sub-module custom_axi_lane_alu, instantiated LANES times via generate.
REQ-022 Design SHALL contain no simulation-only display statements.

Verification
REQ-023 LANES=2, data 0x00000005_00000007, INC, iter 3, ready high -> result 0x00000008_0000000A valid 4 cycles after start, one wen_o pulse, done_cnt_o 1.
REQ-024 SAT_ADD, operand 0xFFFFFFF0, data 0x00000020_00000001, iter 1 -> 0xFFFFFFFF_FFFFFFF1; ADD same inputs -> 0x00000010_FFFFFFF1.
REQ-025 start with iter 0 -> ERROR one cycle, err_code ERR_ZERO_ITER, then IDLE; mode RSVD -> ERR_BAD_MODE.
REQ-026 abort_i on 2nd BUSY cycle of iter 5 -> ERROR, ERR_ABORT, no result_valid_o, no wen_o.
REQ-027 result_ready_i held low 10 cycles in DONE -> result_o stable, wen_o single pulse, repeated start_i ignored; ready high -> IDLE.
REQ-028 rst_i asserted asynchronously mid-BUSY -> all outputs at reset values before next clock edge.

Source files
------------

// File: rtl/custom_axi_lane_engine_pkg.sv
// Shared types for the lane engine.
// States, modes and error causes.
package custom_axi_ip_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BUSY  = 3'd1,
    DONE  = 3'd2,
    ERROR = 3'd3
  } status_e;

  typedef enum logic [1:0] {
    INC     = 2'd0,
    ADD     = 2'd1,
    SAT_ADD = 2'd2,
    RSVD    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ZERO_ITER = 3'd1,
    ERR_BAD_MODE  = 3'd2,
    ERR_ABORT     = 3'd3,
    ERR_STATE     = 3'd4
  } err_e;

endpackage

// File: rtl/custom_axi_lane_engine_if.sv
// Request/result bundle of the lane engine.
// slave = engine side, master = requester side.
interface custom_axi_lane_engine_if #(
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 2,
  parameter int ITER_W     = 8
);
  import custom_axi_ip_pkg::*;

  localparam int LANE_W = DATA_WIDTH / LANES;

  logic                  start_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic [LANE_W-1:0]     operand_i;
  mode_e                 mode_i;
  logic [ITER_W-1:0]     iter_i;
  logic                  abort_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic                  wen_o;
  status_e               status_o;
  logic                  busy_o;
  err_e                  err_code_o;
  logic [15:0]           done_cnt_o;

  modport slave (
    input  start_i, data_i, operand_i,
    input  mode_i, iter_i, abort_i,
    input  result_ready_i,
    output result_o, result_valid_o,
    output wen_o, status_o, busy_o,
    output err_code_o, done_cnt_o
  );

  modport master (
    output start_i, data_i, operand_i,
    output mode_i, iter_i, abort_i,
    output result_ready_i,
    input  result_o, result_valid_o,
    input  wen_o, status_o, busy_o,
    input  err_code_o, done_cnt_o
  );

endinterface

// File: rtl/custom_axi_lane_alu.sv
// Single-lane combinational step: INC, ADD or
// saturating ADD on one LANE_W slice.
module custom_axi_lane_alu
  import custom_axi_ip_pkg::*;
#(
  parameter int W = 32
) (
  input  mode_e        mode_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    y_o = a_i;
    unique case (mode_i)
      INC:     y_o = a_i + W'(1);
      ADD:     y_o = sum[W-1:0];
      SAT_ADD: y_o = sum[W] ? '1 : sum[W-1:0];
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/custom_axi_lane_engine.sv
// Iterative multi-lane engine: latches lanes,
// steps them iter times, then holds result.
module custom_axi_lane_engine
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LANES      = 2,
  parameter int ITER_W     = 8
) (
  input logic clk_i,
  input logic rst_i,
  custom_axi_lane_engine_if.slave bus
);

  localparam int LANE_W = DATA_WIDTH / LANES;

  status_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] lanes_q, lanes_d;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [LANE_W-1:0]     opnd_q, opnd_d;
  mode_e                 mode_q, mode_d;
  logic [ITER_W-1:0]     cnt_q, cnt_d;
  err_e                  err_q, err_d;
  logic [15:0]           done_q, done_d;
  logic                  wen_q, wen_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    custom_axi_lane_alu #(.W(LANE_W)) u_alu (
      .mode_i (mode_q),
      .a_i    (lanes_q[k*LANE_W +: LANE_W]),
      .b_i    (opnd_q),
      .y_o    (alu_y[k*LANE_W +: LANE_W])
    );
  end

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = done_q;
    wen_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.mode_i == RSVD) begin
            state_d = ERROR;
            err_d   = ERR_BAD_MODE;
          end else if (bus.iter_i == '0) begin
            state_d = ERROR;
            err_d   = ERR_ZERO_ITER;
          end else begin
            state_d = BUSY;
            lanes_d = bus.data_i;
            opnd_d  = bus.operand_i;
            mode_d  = bus.mode_i;
            cnt_d   = bus.iter_i;
            err_d   = ERR_NONE;
          end
        end
      end
      BUSY: begin
        // abort beats the final iteration
        if (bus.abort_i) begin
          state_d = ERROR;
          err_d   = ERR_ABORT;
        end else begin
          lanes_d = alu_y;
          cnt_d   = cnt_q - ITER_W'(1);
          if (cnt_q == ITER_W'(1)) begin
            state_d = DONE;
            wen_d   = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.result_ready_i) begin
          state_d = IDLE;
          done_d  = done_q + 16'd1;
        end
      end
      ERROR: state_d = IDLE;
      default: begin
        state_d = ERROR;
        err_d   = ERR_STATE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lanes_q <= '0;
      opnd_q  <= '0;
      mode_q  <= INC;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      done_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
    end
  end

  assign bus.result_o       = lanes_q;
  assign bus.result_valid_o = (state_q == DONE);
  assign bus.wen_o          = wen_q;
  assign bus.status_o       = state_q;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.err_code_o     = err_q;
  assign bus.done_cnt_o     = done_q;

endmodule
